// File: rtl/halfword_pkg.sv
// Shared definitions for the halfword window controller and the shift register it feeds.
package halfword_pkg;

  localparam int HW_DEPTH = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LO    = 3'd1,
    HI    = 3'd2,
    DRAIN = 3'd3,
    FULL  = 3'd4
  } state_t;

endpackage

// File: rtl/halfword_window_ctrl.sv
// Pairs an incoming byte stream into halfwords, pulses the shift register once per halfword,
// and holds a full window until the consumer acknowledges it.
module halfword_window_ctrl
  import halfword_pkg::*;
#(
  parameter  int DEPTH = HW_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             sh_ena,
  output logic [15:0]      sh_data,
  output logic             win_valid,
  input  logic             win_ack,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  state_t     state;
  logic [7:0] low_byte;
  logic       hs;

  // flush masks in_ready so an aborted cycle never consumes a byte
  assign in_ready = ((state == LO) || (state == HI)) && !flush;
  assign hs       = in_valid && in_ready;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      sh_ena    <= 1'b0;
      sh_data   <= '0;
      win_valid <= 1'b0;
      busy      <= 1'b0;
      count     <= '0;
    end else begin
      sh_ena <= 1'b0;
      if (flush) begin
        state     <= IDLE;
        win_valid <= 1'b0;
        busy      <= 1'b0;
        count     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= LO;
              busy  <= 1'b1;
            end
          end
          LO: begin
            if (hs) state <= HI;
          end
          HI: begin
            if (hs) begin
              sh_data <= {in_data, low_byte};
              sh_ena  <= 1'b1;
              count   <= count + 1'b1;
              state   <= (count == CNT_W'(DEPTH - 1)) ? DRAIN : LO;
            end
          end
          DRAIN: begin
            // last shift lands on the negedge inside this cycle
            state     <= FULL;
            win_valid <= 1'b1;
          end
          FULL: begin
            if (win_ack) begin
              state     <= IDLE;
              win_valid <= 1'b0;
              busy      <= 1'b0;
              count     <= '0;
            end
          end
          default: begin
            state     <= IDLE;
            win_valid <= 1'b0;
            busy      <= 1'b0;
            count     <= '0;
          end
        endcase
      end
    end
  end

  // Low byte holding register carries data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (state == LO && hs) low_byte <= in_data;
  end

endmodule

// File: tb/tb_halfword_window_ctrl.sv
// Scoreboard bench for halfword_window_ctrl with a behavioural 16-deep negedge shift register.
module tb_halfword_window_ctrl;
  import halfword_pkg::*;

  localparam int DEPTH = HW_DEPTH;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rstb;
  logic             start, flush, in_valid, win_ack;
  logic [7:0]       in_data;
  logic             in_ready, sh_ena, win_valid, busy;
  logic [15:0]      sh_data;
  logic [CNT_W-1:0] count;

  halfword_window_ctrl dut (
    .clk(clk), .rstb(rstb), .start(start), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sh_ena(sh_ena), .sh_data(sh_data), .win_valid(win_valid),
    .win_ack(win_ack), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  // Environment shift register: out0 = sr[0] is the newest halfword.
  logic [15:0] sr [DEPTH];
  always @(negedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (sh_ena) begin
      for (int i = DEPTH - 1; i > 0; i--) sr[i] <= sr[i-1];
      sr[0] <= sh_data;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];   // {expected count, expected sh_data}
  logic [15:0] hist[$];    // every halfword the reference says has been shifted since reset
  int nh = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every shift pulse must match the next halfword the driver completed.
  always @(negedge clk) begin
    if (rstb === 1'b1 && sh_ena === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_sh_ena", 32'(sh_data), 32'hDEAD_0000);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sh_data", 32'(sh_data), 32'(e[15:0]));
        check("count_at_pulse", 32'(count), 32'(e[31:16]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int pct);
    int  guard;
    logic acc;
    guard = 0;
    forever begin
      while ($urandom_range(99) >= pct && guard < 200) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        guard++;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      guard++;
      if (guard > 200) begin
        check("byte_accept_timeout", 32'(guard), 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic fill(input logic [7:0] base, input int pct, input bit noise, input int halfwords);
    logic [7:0] lo, hi;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (noise) begin
      start   = 1'b1;
      win_ack = 1'b1;
    end
    for (int h = 0; h < halfwords; h++) begin
      lo = base + 8'(2 * h);
      hi = lo + 8'd1;
      send_byte(lo, pct);
      send_byte(hi, pct);
      nh++;
      exp_q.push_back({16'(nh), hi, lo});
      hist.push_back({hi, lo});
    end
    start   = 1'b0;
    win_ack = 1'b0;
  endtask

  task automatic check_window();
    int idx;
    for (int j = 0; j < DEPTH; j++) begin
      idx = hist.size() - 1 - j;
      check($sformatf("out%0d", j), 32'(sr[j]), (idx >= 0) ? 32'(hist[idx]) : 32'd0);
    end
  endtask

  // Called right after the posedge that accepted the final byte.
  task automatic expect_full();
    @(negedge clk);
    check("win_valid_in_drain", 32'(win_valid), 32'd0);
    @(posedge clk); #1;
    check("win_valid_full", 32'(win_valid), 32'd1);
    check("count_full", 32'(count), 32'(DEPTH));
    check("busy_full", 32'(busy), 32'd1);
    check_window();
  endtask

  task automatic ack();
    win_ack = 1'b1;
    @(posedge clk); #1;
    win_ack = 1'b0;
    check("ack_busy", 32'(busy), 32'd0);
    check("ack_count", 32'(count), 32'd0);
    check("ack_win_valid", 32'(win_valid), 32'd0);
    nh = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstb = 1'b0; start = 1'b0; flush = 1'b0; in_valid = 1'b0; win_ack = 1'b0; in_data = '0;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_sh_ena", 32'(sh_ena), 32'd0);
    check("rst_sh_data", 32'(sh_data), 32'd0);
    check("rst_win_valid", 32'(win_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    @(posedge clk); #1;

    // Back-to-back fill with bytes 0x00..0x1F
    fill(8'h00, 100, 1'b0, DEPTH);
    expect_full();
    check("s1_out0", 32'(sr[0]), 32'h1F1E);
    check("s1_out15", 32'(sr[DEPTH-1]), 32'h0100);
    ack();

    // Same data, random valid gaps; then FULL held under start/in_valid pressure
    fill(8'h00, 50, 1'b0, DEPTH);
    expect_full();
    check("s2_out0", 32'(sr[0]), 32'h1F1E);
    check("s2_out15", 32'(sr[DEPTH-1]), 32'h0100);
    in_valid = 1'b1; start = 1'b1; in_data = 8'h5A;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_count", 32'(count), 32'(DEPTH));
      check("full_win_valid", 32'(win_valid), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; start = 1'b0;
    ack();

    // flush in HI with a same-cycle valid byte
    fill(8'($urandom), 100, 1'b0, 2);
    send_byte(8'h77, 100);
    in_valid = 1'b1; in_data = 8'hAA; flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_count", 32'(count), 32'd0);
    check("flush_sh_ena", 32'(sh_ena), 32'd0);
    nh = 0;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("start_flush_busy", 32'(busy), 32'd0);
    fill(8'($urandom), 70, 1'b0, DEPTH);
    expect_full();
    ack();

    // win_ack during LO and start during HI are ignored
    fill(8'($urandom), 60, 1'b1, DEPTH);
    expect_full();
    ack();

    // Asynchronous reset after 7 halfwords
    fill(8'($urandom), 100, 1'b0, 7);
    #2 rstb = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_sh_ena", 32'(sh_ena), 32'd0);
    check("arst_sh_data", 32'(sh_data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    exp_q.delete();
    hist.delete();
    nh = 0;
    check_window();
    @(posedge clk); #1;
    rstb = 1'b1;
    @(posedge clk); #1;
    fill(8'($urandom), 80, 1'b0, DEPTH);
    expect_full();
    ack();

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
